// File: rtl/fpu_seq.sv
// Request sequencer in front of the shared FP add/mul/div engine; FPU_SEQ_TIMEOUT_EN adds a WAIT watchdog.
// Latency: pop one cycle after accept, one-cycle dval, response one cycle after engine rdy (illegal cmd: 1 cycle).
// Backpressure: req_ready drops when the FIFO is full; rsp_ready low parks the FSM in DONE.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module fpu_seq #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_din1,
  input  logic [31:0] req_din2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_cmd,
  output logic        rsp_err,
  output logic [3:0]  fpu_cmd,
  output logic [31:0] fpu_din1,
  output logic [31:0] fpu_din2,
  output logic        fpu_dval,
  input  logic [31:0] fpu_result,
  input  logic        fpu_rdy,
  output logic        busy
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] din1;
    logic [31:0] din2;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  req_t   push_dat;
  req_t   head_dat;
  req_t   op_q;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd3);
  endfunction

  // Gated by rst_n so the requester sees no room while the block is held in reset.
  assign req_ready = rst_n & ~fifo_full;
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign push_dat  = '{cmd: req_cmd, din1: req_din1, din2: req_din2};

  fifo #(.W($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_dat),
    .pop   (pop),
    .dout  (head_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      fpu_dval   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            op_q <= head_dat;
            if (cmd_legal(head_dat.cmd)) begin
              fpu_dval <= 1'b1;
              state    <= ISSUE;
            end else begin
              // Illegal commands never reach the engine.
              rsp_result <= QNAN;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        ISSUE: begin
          fpu_dval <= 1'b0;
          state    <= WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
        WAIT: begin
          if (fpu_rdy) begin
            rsp_result <= fpu_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            rsp_result <= QNAN;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Engine bus and response cmd come straight from the operation register, so they only move on a pop.
  assign fpu_cmd  = op_q.cmd;
  assign fpu_din1 = op_q.din1;
  assign fpu_din2 = op_q.din2;
  assign rsp_cmd  = op_q.cmd;
  assign busy     = (state != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_fpu_seq.sv
// Randomized bench for fpu_seq: behavioural engine stub plus an in-order response scoreboard.
module tb_fpu_seq;
  localparam int DEPTH = 4;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif
  localparam int SLOW = (TMO > 22) ? 20 : TMO - 2;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, fpu_dval, fpu_rdy, busy;
  logic [3:0] req_cmd, rsp_cmd, fpu_cmd;
  logic [31:0] req_din1, req_din2, rsp_result, fpu_din1, fpu_din2, fpu_result;

  always #5 clk = ~clk;

  fpu_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_din1(req_din1), .req_din2(req_din2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cmd(rsp_cmd), .rsp_err(rsp_err),
    .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_dval(fpu_dval),
    .fpu_result(fpu_result), .fpu_rdy(fpu_rdy), .busy(busy)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Engine stub: true IEEE sum for the directed 1.0+2.0 case, a deterministic mix otherwise.
  function automatic logic [31:0] eng_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 4'd1 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {28'd0, c};
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd3);
  endfunction

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t acc_e;
  exp_t got_e;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   legal_rsp = 0;
  int   dval_cnt = 0;
  int   stab_err = 0;
  int   last_acc_edge = 0;
  bit   tmo_mode = 0;
  bit   never_rdy = 0;
  bit   stale_rdy = 0;
  bit   rnd_rdy = 0;
  bit   rsp_hold = 1;
  int   eng_lat = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry is formed at acceptance from the request alone.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      acc_e.cmd = req_cmd;
      if (!is_legal(req_cmd) || tmo_mode) begin
        acc_e.res = QNAN;
        acc_e.err = 1'b1;
      end else begin
        acc_e.res = eng_fn(req_cmd, req_din1, req_din2);
        acc_e.err = 1'b0;
      end
      exp_q.push_back(acc_e);
      acc_cnt++;
      last_acc_edge = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("rsp_cmd", {28'd0, rsp_cmd}, {28'd0, got_e.cmd});
        check("rsp_result", rsp_result, got_e.res);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, got_e.err});
        rsp_cnt++;
        if (is_legal(got_e.cmd)) legal_rsp++;
      end
    end
  end

  // Engine bus must hold from the dval strobe until the response is taken.
  logic [67:0] snap;
  bit          snap_vld = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      snap_vld = 0;
    end else begin
      if (fpu_dval) begin
        dval_cnt++;
        if (snap_vld) stab_err++;
        snap = {fpu_cmd, fpu_din1, fpu_din2};
        snap_vld = 1;
      end else if (snap_vld && ({fpu_cmd, fpu_din1, fpu_din2} != snap)) begin
        stab_err++;
      end
      if (snap_vld && rsp_valid && rsp_ready) snap_vld = 0;
    end
  end

  logic [3:0]  eng_c;
  logic [31:0] eng_a, eng_b;
  bit          eng_pend = 0;
  int          eng_cnt = 0;
  initial begin
    fpu_rdy = 1'b0;
    fpu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        eng_pend = 0;
        fpu_rdy = stale_rdy;
      end else begin
        if (eng_pend) begin
          if (eng_cnt > 1) eng_cnt--;
          else begin
            fpu_rdy = 1'b1;
            fpu_result = eng_fn(eng_c, eng_a, eng_b);
            eng_pend = 0;
          end
        end
        if (fpu_dval) begin
          fpu_rdy = 1'b0;
          fpu_result = 32'hDEAD_BEEF;
          eng_c = fpu_cmd;
          eng_a = fpu_din1;
          eng_b = fpu_din2;
          if (!never_rdy) begin
            eng_pend = 1;
            eng_cnt = eng_lat;
          end
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : rsp_hold;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int  t;
    logic acc;
    t = 0;
    req_cmd = c;
    req_din1 = a;
    req_din2 = b;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_lat(input string tag, input int exp_lat);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 200);
    check(tag, cyc - last_acc_edge, exp_lat);
  endtask

  task automatic drain(input string tag, input int bound);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < bound) begin
      tick(1);
      t++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  int d0, l0, a0, r0;
  logic [3:0] c;
  int r;

  initial begin
    req_valid = 1'b0;
    req_cmd = '0;
    req_din1 = '0;
    req_din2 = '0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_cmd", {28'd0, rsp_cmd}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_fpu_cmd", {28'd0, fpu_cmd}, 32'd0);
    check("rst_fpu_din1", fpu_din1, 32'd0);
    check("rst_fpu_din2", fpu_din2, 32'd0);
    check("rst_fpu_dval", {31'd0, fpu_dval}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Directed ADD, one-cycle engine.
    eng_lat = 1;
    d0 = dval_cnt;
    send(4'd1, 32'h3F80_0000, 32'h4000_0000);
    wait_lat("add_latency", 3);
    drain("add_drain", 100);
    check("add_dval_pulses", dval_cnt - d0, 32'd1);

    // Illegal command, then a legal one.
    d0 = dval_cnt;
    send(4'h7, $urandom, $urandom);
    wait_lat("ill_latency", 1);
    drain("ill_drain", 100);
    check("ill_no_dval", dval_cnt - d0, 32'd0);
    send(4'd2, $urandom, $urandom);
    wait_lat("after_ill_latency", 3);
    drain("after_ill_drain", 100);
    check("after_ill_dval", dval_cnt - d0, 32'd1);

    // Fill with responses stalled.
    rsp_hold = 0;
    tick(2);
    eng_lat = 2;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    for (int i = 0; i < 5; i++) send(4'(1 + (i % 3)), $urandom, $urandom);
    tick(8);
    check("fill_accepts", acc_cnt - a0, 32'd5);
    check("fill_req_ready", {31'd0, req_ready}, 32'd0);
    check("fill_busy", {31'd0, busy}, 32'd1);
    check("fill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_hold = 1;
    drain("fill_drain", 200);
    check("fill_rsp_count", rsp_cnt - r0, 32'd5);

    // Slow engine: bus must stay put for the whole wait.
    eng_lat = SLOW;
    d0 = dval_cnt;
    send(4'd3, $urandom, $urandom);
    wait_lat("slow_latency", SLOW + 2);
    drain("slow_drain", 200);
    check("slow_dval_pulses", dval_cnt - d0, 32'd1);
    check("slow_stable", stab_err, 32'd0);

    // Randomized traffic with random response backpressure.
    rnd_rdy = 1;
    d0 = dval_cnt;
    l0 = legal_rsp;
    r0 = rsp_cnt;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) c = 4'(1 + (r % 3));
      else if (r == 8) c = 4'h0;
      else c = 4'(4 + $urandom_range(0, 11));
      eng_lat = $urandom_range(1, 6);
      send(c, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
    end
    drain("rnd_drain", 3000);
    rnd_rdy = 0;
    tick(2);
    check("rnd_rsp_count", rsp_cnt - r0, 32'd40);
    check("rnd_dval_vs_legal", dval_cnt - d0, legal_rsp - l0);
    check("rnd_stable", stab_err, 32'd0);

    // Reset in WAIT with two entries queued.
    eng_lat = 30;
    send(4'd1, $urandom, $urandom);
    send(4'd2, $urandom, $urandom);
    send(4'd3, $urandom, $urandom);
    tick(4);
    r0 = rsp_cnt;
    stale_rdy = 1;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_fpu_cmd", {28'd0, fpu_cmd}, 32'd0);
    check("mid_rst_fpu_din1", fpu_din1, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dval_cnt;
    tick(10);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_req_ready2", {31'd0, req_ready}, 32'd1);
    check("post_rst_no_rsp", rsp_cnt - r0, 32'd0);
    check("post_rst_no_dval", dval_cnt - d0, 32'd0);
    stale_rdy = 0;
    eng_lat = 2;
    send(4'd2, $urandom, $urandom);
    wait_lat("post_rst_latency", 4);
    drain("post_rst_drain", 100);
    check("post_rst_rsp", rsp_cnt - r0, 32'd1);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Engine never answers: watchdog returns an error response.
    tmo_mode = 1;
    never_rdy = 1;
    send(4'd1, $urandom, $urandom);
    wait_lat("tmo_latency", TMO + 2);
    drain("tmo_drain", 200);
    tmo_mode = 0;
    never_rdy = 0;
    eng_lat = 1;
    send(4'd3, $urandom, $urandom);
    wait_lat("after_tmo_latency", 3);
    drain("after_tmo_drain", 100);
`endif

    check("final_stable", stab_err, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
